// File: rtl/send_msg.sv
`default_nettype none
// ============================================================================
//  Module   : send_msg
//  Purpose  : Serialises a 3-byte motor command (lmotor, rmotor, dur) onto a
//             UART-style line: per byte one start bit (0), eight data bits
//             LSB first, then STOP_BITS stop bits (1). Bytes of one message
//             are sent back to back with no idle gap.
//  Ports    : clk    - system clock, rising-edge active
//             reset  - asynchronous, active-high reset
//             start  - request to send one message (accepted only when idle)
//             lmotor - first byte of the message
//             rmotor - second byte of the message
//             dur    - third byte of the message
//             TX     - registered serial output, idle high
//             busy   - high while a message is in flight
//             done   - one-cycle pulse in the first idle cycle after a message
//  Revision : 1.0  initial release
// ============================================================================
module send_msg #(
    parameter int CLKS_PER_BIT = 16,  // clk cycles per serial bit, 2..255
    parameter int STOP_BITS    = 2    // stop bits per byte, 1 or 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] lmotor,
    input  logic [7:0] rmotor,
    input  logic [7:0] dur,
    output logic       TX,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] c_BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic       c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [1:0] c_BYTE_LAST = 2'd2;
    localparam logic [2:0] c_BIT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t     r_state,    w_state;
    logic [1:0] r_byte_idx, w_byte_idx;
    logic [2:0] r_bit_idx,  w_bit_idx;
    logic [7:0] r_baud,     w_baud;
    logic       r_stop_idx, w_stop_idx;
    logic [7:0] r_lm, r_rm, r_dur;
    logic       r_tx,   w_tx;
    logic       r_done, w_done;
    logic       w_capture;
    logic       w_baud_end;
    logic [7:0] w_cur_byte;

    // Next-state logic. TX is computed from the *next* state so that the
    // registered line already shows the new bit in the cycle after the edge
    // that changes state (start bit appears in the first cycle after accept).
    always_comb begin
        w_state    = r_state;
        w_byte_idx = r_byte_idx;
        w_bit_idx  = r_bit_idx;
        w_baud     = r_baud;
        w_stop_idx = r_stop_idx;
        w_done     = 1'b0;
        w_capture  = 1'b0;
        w_baud_end = (r_baud == c_BAUD_LAST);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture  = 1'b1;
                    w_state    = S_START;
                    w_byte_idx = 2'd0;
                    w_bit_idx  = 3'd0;
                    w_stop_idx = 1'b0;
                    w_baud     = 8'd0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud    = 8'd0;
                    w_bit_idx = 3'd0;
                    w_state   = S_DATA;
                end else begin
                    w_baud = r_baud + 8'd1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud = 8'd0;
                    if (r_bit_idx == c_BIT_LAST) begin
                        w_bit_idx  = 3'd0;
                        w_stop_idx = 1'b0;
                        w_state    = S_STOP;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud = r_baud + 8'd1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud = 8'd0;
                    if (r_stop_idx == c_STOP_LAST) begin
                        w_stop_idx = 1'b0;
                        if (r_byte_idx == c_BYTE_LAST) begin
                            w_state = S_IDLE;
                            w_done  = 1'b1;
                        end else begin
                            w_byte_idx = r_byte_idx + 2'd1;
                            w_state    = S_START;
                        end
                    end else begin
                        w_stop_idx = r_stop_idx + 1'b1;
                    end
                end else begin
                    w_baud = r_baud + 8'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Captured bytes are only read in DATA, never in the accept cycle.
        case (w_byte_idx)
            2'd0:    w_cur_byte = r_lm;
            2'd1:    w_cur_byte = r_rm;
            default: w_cur_byte = r_dur;
        endcase

        case (w_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = w_cur_byte[w_bit_idx];
            default: w_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_bit_idx  <= 3'd0;
            r_baud     <= 8'd0;
            r_stop_idx <= 1'b0;
            r_lm       <= 8'd0;
            r_rm       <= 8'd0;
            r_dur      <= 8'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_byte_idx <= w_byte_idx;
            r_bit_idx  <= w_bit_idx;
            r_baud     <= w_baud;
            r_stop_idx <= w_stop_idx;
            r_tx       <= w_tx;
            r_done     <= w_done;
            if (w_capture) begin
                r_lm  <= lmotor;
                r_rm  <= rmotor;
                r_dur <= dur;
            end
        end
    end

    // busy decodes the state register directly, so an asynchronous reset
    // drops it immediately along with TX.
    assign TX   = r_tx;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire
